// File: rtl/md_pkg.sv
// Shared opcodes, FSM states and decode helpers for the multiply/divide unit.
// Used by the md unit, the hazard controller and the ALU decoder.
package md_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd3,
    MD_MULTU = 4'd4,
    MD_DIV   = 4'd8,
    MD_DIVU  = 4'd9,
    MD_MTHI  = 4'd10,
    MD_MTLO  = 4'd11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_mul(input logic [3:0] o);
    return (o == MD_MULT) || (o == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: latched op/a/b -> hi/lo results.
// Ports: op,a,b in; hi_res,lo_res,div_zero out (div_zero: DIV/DIVU by zero).
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic        sgn_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Signed divide is done on magnitudes so the
  // 0x80000000 / -1 case wraps instead of trapping.
  always_comb begin
    sgn_div  = (op == MD_DIV);
    a_neg    = sgn_div & a[31];
    b_neg    = sgn_div & b[31];
    a_mag    = a_neg ? (~a + 32'd1) : a;
    b_mag    = b_neg ? (~b + 32'd1) : b;
    div_zero = md_is_div(op) && (b == 32'd0);
    uq       = 32'd0;
    ur       = 32'd0;
    if (b_mag != 32'd0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    q = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    r = a_neg ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    unique case (1'b1)
      (op == MD_MULT):  {hi_res, lo_res} = prod_s;
      (op == MD_MULTU): {hi_res, lo_res} = prod_u;
      md_is_div(op): begin
        hi_res = r;
        lo_res = q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO.
// Ports: clk,reset(async low),start,op,rs,rt in; busy,done,hi,lo out.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

  md_state_e   state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;
  logic [3:0]  op_q, op_n;
  logic [31:0] a_q, a_n;
  logic [31:0] b_q, b_n;

  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div_zero;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      op_q    <= op_n;
      a_q     <= a_n;
      b_q     <= b_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    hi_n    = hi_q;
    lo_n    = lo_q;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          unique case (1'b1)
            md_is_mul(op): begin
              op_n    = op;
              a_n     = rs;
              b_n     = rt;
              cnt_n   = MC;
              busy_n  = 1'b1;
              state_n = MD_RUN;
            end
            md_is_div(op): begin
              op_n    = op;
              a_n     = rs;
              b_n     = rt;
              cnt_n   = DC;
              busy_n  = 1'b1;
              state_n = MD_RUN;
            end
            (op == MD_MTHI): hi_n = rs;
            (op == MD_MTLO): lo_n = rs;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_n = MD_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          // Divide by zero leaves HI/LO untouched.
          if (!div_zero) begin
            hi_n = hi_res;
            lo_n = lo_res;
          end
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
